// File: rtl/ins_mem_prog_if.sv
// rtl/ins_mem_prog_if.sv - program-loader bundle between a byte-stream loader and ins_mem_prog
//
// Signals:
//   load_start  loader -> mem   start request, honoured only while the memory is running
//   load_len    loader -> mem   number of words to load, sampled with load_start
//   ld_valid    loader -> mem   byte valid
//   ld_byte     loader -> mem   byte data, little-endian within each word
//   ld_ready    mem -> loader   byte ready (high for the whole load)
//   load_done   mem -> loader   one-cycle pulse after the last word is written
//   load_count  mem -> loader   words written in the current or last load
//
// Modports: master = loader side, slave = memory side.

interface ins_mem_prog_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;

  modport master (
    output load_start, load_len, ld_valid, ld_byte,
    input  ld_ready, load_done, load_count
  );

  modport slave (
    input  load_start, load_len, ld_valid, ld_byte,
    output ld_ready, load_done, load_count
  );
endinterface

// File: rtl/ins_mem_prog.sv
// rtl/ins_mem_prog.sv - run-time loadable instruction memory with combinational fetch
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   pointer      fetch byte address (PC)
//   ins          fetched instruction, combinational; NOP on fault or while loading
//   fetch_fault  pointer misaligned or outside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
//   stall        high while a program load is in progress; the core must hold PC
//   ld           ins_mem_prog_if.slave loader bundle

module ins_mem_prog #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INS   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pointer,
  output logic [31:0]   ins,
  output logic          fetch_fault,
  output logic          stall,
  ins_mem_prog_if.slave ld
);

  localparam int              DEPTH      = 1 << ADDR_W;
  // Byte span of the memory; 33 bits so 4*DEPTH cannot wrap for large ADDR_W.
  localparam logic [32:0]     FETCH_SPAN = 33'(DEPTH) << 2;
  localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic {S_RUN, S_LOAD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_load_count;
  logic [ADDR_W-1:0] r_wptr;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;
  logic              r_load_done;
  logic [31:0]       r_mem [DEPTH];

  logic [31:0]       w_off;
  logic [ADDR_W-1:0] w_idx;
  logic              w_fault;
  logic              w_ld_ready;
  logic              w_start;
  logic              w_accept;
  logic              w_word_wr;
  logic              w_last;

  // Fetch decode, independent of the FSM state.
  assign w_off   = pointer - BASE_ADDR;
  assign w_idx   = w_off[ADDR_W+1:2];
  assign w_fault = (pointer[1:0] != 2'b00) | (pointer < BASE_ADDR) |
                   ({1'b0, w_off} >= FETCH_SPAN);

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ready  = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_word_wr   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_RUN: begin
        // A zero-length request is dropped rather than entering LOAD.
        if (ld.load_start && (ld.load_len != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ld_ready = 1'b1;
        w_accept   = ld.ld_valid;
        w_word_wr  = ld.ld_valid && (r_byte_idx == 2'd3);
        w_last     = w_word_wr && ((r_load_count + CNT_ONE) == r_len);
        if (w_last) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len        <= '0;
      r_wptr       <= '0;
      r_byte_idx   <= '0;
      r_load_count <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= w_last;
      if (w_start) begin
        r_len        <= (ld.load_len > DEPTH_CNT) ? DEPTH_CNT : ld.load_len;
        r_wptr       <= '0;
        r_byte_idx   <= '0;
        r_load_count <= '0;
      end else if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (w_word_wr) begin
          r_wptr       <= r_wptr + 1'b1;
          r_load_count <= r_load_count + CNT_ONE;
        end
      end
    end
  end

  // Storage is never reset; writes are held off while reset is asserted so
  // a partially assembled word is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      case (r_byte_idx)
        2'd0:    r_word[7:0]   <= ld.ld_byte;
        2'd1:    r_word[15:8]  <= ld.ld_byte;
        2'd2:    r_word[23:16] <= ld.ld_byte;
        default: r_mem[r_wptr] <= {ld.ld_byte, r_word};
      endcase
    end
  end

  assign stall         = (r_state == S_LOAD);
  assign ld.ld_ready   = w_ld_ready;
  assign ld.load_done  = r_load_done;
  assign ld.load_count = r_load_count;
  assign fetch_fault   = w_fault;

  always_comb begin
    ins = r_mem[w_idx];
    if (w_fault || stall) begin
      ins = NOP_INS;
    end
  end

endmodule

// File: tb/tb_ins_mem_prog.sv
// tb/tb_ins_mem_prog.sv - randomized self-checking bench for ins_mem_prog

module tb_ins_mem_prog;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pointer;
  logic [31:0] ins;
  logic        fetch_fault;
  logic        stall;

  ins_mem_prog_if #(.ADDR_W(ADDR_W)) ldif ();

  ins_mem_prog #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(32'h0000_0000),
    .NOP_INS  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pointer    (pointer),
    .ins        (ins),
    .fetch_fault(fetch_fault),
    .stall      (stall),
    .ld         (ldif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a load is "len words, fed as a byte stream"; words
  // land in an array as each group of four bytes completes.
  bit          m_loading = 1'b0;
  int          m_len     = 0;
  int          m_count   = 0;
  bit          m_done    = 1'b0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_mem[DEPTH];
  bit          m_known[DEPTH];

  initial begin
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) begin
        m_loading = 1'b0;
        m_count   = 0;
        m_done    = 1'b0;
        m_bytes.delete();
      end else begin
        m_done = 1'b0;
        if (!m_loading) begin
          if (ldif.load_start === 1'b1 && ldif.load_len != 0) begin
            m_loading = 1'b1;
            m_len     = (int'(ldif.load_len) > DEPTH) ? DEPTH : int'(ldif.load_len);
            m_count   = 0;
            m_bytes.delete();
          end
        end else if (ldif.ld_valid === 1'b1) begin
          m_bytes.push_back(ldif.ld_byte);
          if (m_bytes.size() == 4) begin
            m_mem[m_count]   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_known[m_count] = 1'b1;
            m_count++;
            m_bytes.delete();
            if (m_count == m_len) begin
              m_loading = 1'b0;
              m_done    = 1'b1;
            end
          end
        end
      end
    end
  end

  bit   chk_en        = 1'b0;
  int   cyc           = 0;
  int   stall_cyc     = 0;
  int   done_cnt      = 0;
  int   last_done_cyc = 0;
  logic exp_fault;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        exp_fault = (pointer[1:0] != 2'b00) || (pointer >= 32'd1024);
        chk("stall", 32'(stall), 32'(m_loading));
        chk("ld_ready", 32'(ldif.ld_ready), 32'(m_loading));
        chk("load_done", 32'(ldif.load_done), 32'(m_done));
        chk("load_count", 32'(ldif.load_count), 32'(m_count));
        chk("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
        if (exp_fault || m_loading) begin
          chk("ins_nop", ins, NOP);
        end else if (m_known[pointer[9:2]]) begin
          chk("ins", ins, m_mem[pointer[9:2]]);
        end
        if (stall === 1'b1) stall_cyc++;
        if (ldif.load_done === 1'b1) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit ptr_rand  = 1'b0;
  int first_cyc = 0;

  function automatic logic [31:0] rand_ptr();
    case ($urandom_range(0, 9))
      0:       rand_ptr = 32'($urandom_range(0, 1023)) | 32'($urandom_range(1, 3));
      1:       rand_ptr = 32'd1024 + (32'($urandom_range(0, 4000)) & ~32'd3);
      2:       rand_ptr = 32'd1020;
      3:       rand_ptr = $urandom;
      default: rand_ptr = 32'($urandom_range(0, 255)) << 2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ptr_rand) pointer = rand_ptr();
  endtask

  // mode 0: back-to-back, 1: valid toggles 1/0, 2: random gaps.
  // inject >= 0 raises a second load_start alongside that byte index.
  task automatic run_load(input int len, input logic [7:0] bytes[$], input int mode, input int inject);
    bit ok;
    int tries;
    tick();
    ldif.load_start = 1'b1;
    ldif.load_len   = 9'(len);
    stall_cyc = 0;
    done_cnt  = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        tick();
        ldif.load_start = 1'b0;
        ldif.ld_valid   = 1'b0;
      end
      tries = 0;
      ok    = 1'b0;
      while (!ok && tries < 50) begin
        tick();
        ldif.load_start = (i == inject);
        ldif.load_len   = (i == inject) ? 9'd5 : 9'(len);
        ldif.ld_valid   = 1'b1;
        ldif.ld_byte    = bytes[i];
        if (i == 0 && tries == 0) first_cyc = cyc + 1;
        ok = (ldif.ld_ready === 1'b1);
        tries++;
      end
      if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    end
    tick();
    ldif.load_start = 1'b0;
    ldif.ld_valid   = 1'b0;
    tick();
  endtask

  logic [7:0] q[$];
  int         n;

  initial begin
    rst             = 1'b0;
    pointer         = 32'd0;
    ldif.load_start = 1'b0;
    ldif.load_len   = '0;
    ldif.ld_valid   = 1'b0;
    ldif.ld_byte    = '0;

    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ld_ready", 32'(ldif.ld_ready), 32'd0);
    chk("rst_load_done", 32'(ldif.load_done), 32'd0);
    chk("rst_load_count", 32'(ldif.load_count), 32'd0);
    rst      = 1'b1;
    ptr_rand = 1'b1;

    q = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    run_load(2, q, 0, -1);
    chk("basic_stall_cycles", 32'(stall_cyc), 32'd8);
    chk("basic_done_pulses", 32'(done_cnt), 32'd1);
    chk("basic_done_latency", 32'(last_done_cyc - first_cyc), 32'd8);
    chk("basic_load_count", 32'(ldif.load_count), 32'd2);
    ptr_rand = 1'b0;
    pointer = 32'd0; #1 chk("basic_word0", ins, 32'h00500113);
    pointer = 32'd4; #1 chk("basic_word1", ins, 32'h00C00193);

    ptr_rand = 1'b1;
    run_load(2, q, 1, -1);
    chk("throttle_done_latency", 32'(last_done_cyc - first_cyc), 32'd15);
    chk("throttle_done_pulses", 32'(done_cnt), 32'd1);
    ptr_rand = 1'b0;
    pointer = 32'd0; #1 chk("throttle_word0", ins, 32'h00500113);
    pointer = 32'd4; #1 chk("throttle_word1", ins, 32'h00C00193);

    pointer = 32'd2;    #1 chk("fault_misaligned", 32'(fetch_fault), 32'd1);
    chk("fault_misaligned_nop", ins, 32'h00000013);
    pointer = 32'd1024; #1 chk("fault_range", 32'(fetch_fault), 32'd1);
    pointer = 32'd1020; #1 chk("fault_last_word", 32'(fetch_fault), 32'd0);

    // Reset after six bytes of a three-word load.
    q = '{8'h37, 8'h02, 8'h00, 8'h00, 8'hAA, 8'hBB};
    tick();
    ldif.load_start = 1'b1;
    ldif.load_len   = 9'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      ldif.load_start = 1'b0;
      ldif.ld_valid   = 1'b1;
      ldif.ld_byte    = q[i];
    end
    tick();
    ldif.ld_valid = 1'b0;
    rst           = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_load_count", 32'(ldif.load_count), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    pointer = 32'd0; #1 chk("midrst_word0", ins, 32'h00000237);
    pointer = 32'd4; #1 chk("midrst_word1_kept", ins, 32'h00C00193);

    tick();
    ldif.load_start = 1'b1;
    ldif.load_len   = 9'd0;
    tick();
    ldif.load_start = 1'b0;
    tick();
    chk("len0_no_load", 32'(stall), 32'd0);

    ptr_rand = 1'b1;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(2, q, 0, 3);
    chk("restart_ignored_count", 32'(ldif.load_count), 32'd2);
    chk("restart_ignored_done", 32'(done_cnt), 32'd1);

    repeat (20) begin
      n = $urandom_range(1, 12);
      q.delete();
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_load(n, q, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * n - 1)) : -1);
      chk("rand_done_pulses", 32'(done_cnt), 32'd1);
      repeat (4) tick();
    end

    q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
    run_load(300, q, 0, -1);
    chk("len300_count", 32'(ldif.load_count), 32'd256);
    chk("len300_done", 32'(done_cnt), 32'd1);
    chk("len300_stall_cycles", 32'(stall_cyc), 32'd1024);
    ptr_rand = 1'b0;
    pointer = 32'd1020; #1 chk("len300_last_word", ins, {q[1023], q[1022], q[1021], q[1020]});
    ptr_rand = 1'b1;
    repeat (200) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
